// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-RAM arbiter: access sizes, FSM states, access owner
// and the word-index range check.
package mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_WAIT = 2'd1,
    MA_RESP = 2'd2
  } ma_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Word indices wrap nowhere: anything at or beyond the RAM depth is rejected.
  function automatic logic word_in_range(input logic [29:0] idx, input int unsigned depth);
    return idx < 30'(depth);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: store data replication + byte enables and alignment check
// for the request being granted, plus extraction/extension of the returned read word.
module mem_lane_fmt
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_sh,
  output logic        st_align_ok,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be       = 4'b0000;
    st_wdata_sh = st_wdata;
    st_align_ok = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        st_be       = 4'(4'b0001 << st_lo);
        st_wdata_sh = {4{st_wdata[7:0]}};
        st_align_ok = 1'b1;
      end
      SZ_HALF: begin
        st_be       = st_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_sh = {2{st_wdata[15:0]}};
        st_align_ok = ~st_lo[0];
      end
      SZ_WORD: begin
        st_be       = 4'b1111;
        st_align_ok = (st_lo == 2'b00);
      end
      default: ;  // size 11: never aligned, so never reaches the RAM
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign ld_shifted = ld_word >> {ld_lo, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous-read RAM between instruction fetch and the load/store
// unit: one access in flight, LS priority with a starvation guard for IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_WORDS  = 'h2404,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [29:0] ram_addr,
  output logic        ram_en,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  ma_state_t   state_reg, state_next;
  owner_t      owner_reg;
  logic [SW-1:0] starve_cnt_reg;
  logic [1:0]  lat_size_reg;
  logic [1:0]  lat_lo_reg;
  logic        lat_unsigned_reg;
  logic        lat_we_reg;
  logic [31:0] if_rdata_reg, ls_rdata_reg;
  logic        if_err_reg, ls_err_reg;

  logic        any_req, win_ls, grant, req_ok, starve_full, store_go;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_ld_data, load_value;
  logic        fmt_align_ok;

  assign any_req     = if_req | ls_req;
  assign starve_full = (starve_cnt_reg == SW'(STARVE_MAX));
  assign win_ls      = ls_req & ~(if_req & starve_full);
  assign grant       = (state_reg == MA_IDLE) & any_req;
  assign sel_addr    = win_ls ? ls_addr : if_addr;
  assign sel_size    = win_ls ? ls_size : SZ_WORD;
  assign req_ok      = fmt_align_ok & word_in_range(sel_addr[31:2], MEM_WORDS);

  mem_lane_fmt u_fmt (
    .st_size     (sel_size),
    .st_lo       (sel_addr[1:0]),
    .st_wdata    (ls_wdata),
    .st_be       (fmt_be),
    .st_wdata_sh (fmt_wdata),
    .st_align_ok (fmt_align_ok),
    .ld_size     (lat_size_reg),
    .ld_lo       (lat_lo_reg),
    .ld_unsigned (lat_unsigned_reg),
    .ld_word     (ram_rdata),
    .ld_data     (fmt_ld_data)
  );

  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    case (state_reg)
      MA_IDLE: begin
        if (any_req) begin
          ls_gnt     = win_ls;
          if_gnt     = ~win_ls;
          // Illegal requests never touch the RAM and answer one cycle early.
          state_next = req_ok ? MA_WAIT : MA_RESP;
        end
      end
      MA_WAIT: state_next = MA_RESP;
      MA_RESP: state_next = MA_IDLE;
      default: state_next = MA_IDLE;
    endcase
  end

  assign store_go  = grant & req_ok & win_ls & ls_we;
  assign ram_en    = grant & req_ok;
  assign ram_addr  = grant ? sel_addr[31:2] : 30'd0;
  assign ram_be    = store_go ? fmt_be : 4'b0000;
  assign ram_wdata = store_go ? fmt_wdata : 32'd0;
  assign load_value = lat_we_reg ? 32'd0 : fmt_ld_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= MA_IDLE;
      owner_reg        <= OWN_IF;
      starve_cnt_reg   <= '0;
      lat_size_reg     <= SZ_WORD;
      lat_lo_reg       <= 2'b00;
      lat_unsigned_reg <= 1'b0;
      lat_we_reg       <= 1'b0;
      if_rdata_reg     <= 32'd0;
      ls_rdata_reg     <= 32'd0;
      if_err_reg       <= 1'b0;
      ls_err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_reg        <= win_ls ? OWN_LS : OWN_IF;
        lat_size_reg     <= sel_size;
        lat_lo_reg       <= sel_addr[1:0];
        lat_unsigned_reg <= win_ls & ls_unsigned;
        lat_we_reg       <= win_ls & ls_we;
        if (if_gnt)
          starve_cnt_reg <= '0;
        else if (if_req && !starve_full)
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
        if (!req_ok) begin
          if (win_ls) begin
            ls_err_reg   <= 1'b1;
            ls_rdata_reg <= 32'd0;
          end else begin
            if_err_reg   <= 1'b1;
            if_rdata_reg <= 32'd0;
          end
        end
      end
      if (state_reg == MA_WAIT) begin
        if (owner_reg == OWN_LS) begin
          ls_rdata_reg <= load_value;
          ls_err_reg   <= 1'b0;
        end else begin
          if_rdata_reg <= load_value;
          if_err_reg   <= 1'b0;
        end
      end
    end
  end

  assign if_rvalid = (state_reg == MA_RESP) & (owner_reg == OWN_IF);
  assign ls_rvalid = (state_reg == MA_RESP) & (owner_reg == OWN_LS);
  assign if_rdata  = if_rdata_reg;
  assign ls_rdata  = ls_rdata_reg;
  assign if_err    = if_err_reg;
  assign ls_err    = ls_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-enable RAM behind it.
module tb_mem_arbiter;

  localparam int MEM_WORDS  = 'h2404;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0;
  logic [1:0]  ls_size = 2'b10;
  logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic [29:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:MEM_WORDS-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic ls_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output logic [3:0] be, output logic en, output int lat);
    int k;
    ls_req = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = a; ls_wdata = wd;
    #1;
    k = 0;
    while (!ls_gnt && k < 8) begin @(posedge clk); #2; k++; end
    check("ls_gnt", 32'(ls_gnt), 32'd1);
    be = ram_be; en = ram_en;
    @(posedge clk); #1;
    ls_req = 1'b0;
    lat = 1;
    while (!ls_rvalid && lat < 6) begin @(posedge clk); #1; lat++; end
    rd = ls_rdata; er = ls_err;
    @(posedge clk); #1;
  endtask

  task automatic ld_chk(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] exp_rd);
    logic [31:0] rd; logic er, en; logic [3:0] be; int lat;
    ls_op(1'b0, sz, uns, a, 32'd0, rd, er, be, en, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  task automatic st_chk(input string tag, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] exp_be);
    logic [31:0] rd; logic er, en; logic [3:0] be; int lat;
    ls_op(1'b1, sz, 1'b0, a, wd, rd, er, be, en, lat);
    check({tag, "_be"}, 32'(be), 32'(exp_be));
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] a);
    logic [31:0] rd; logic er, en; logic [3:0] be; int lat;
    ls_op(we, sz, 1'b0, a, 32'hDEADBEEF, rd, er, be, en, lat);
    check({tag, "_ram_en"}, 32'(en), 32'd0);
    check({tag, "_err"}, 32'(er), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  initial begin
    int k, lat, n_if_g, n_ls_g, n_if_v, n_ls_v, n_both, gidx;
    logic [9:0] seq;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    check("rst_rdata", if_rdata | ls_rdata, 32'd0);
    check("rst_err", {30'd0, if_err, ls_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // instruction fetch of word 4
    st_chk("sw_0x10", 2'b10, 32'h10, 32'h00500093, 4'b1111);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("if_gnt_T", 32'(if_gnt), 32'd1);
    check("if_ram_addr", 32'(ram_addr), 32'd4);
    @(posedge clk); #1;
    if_req = 1'b0;
    lat = 1;
    while (!if_rvalid && lat < 6) begin @(posedge clk); #1; lat++; end
    check("if_lat", 32'(lat), 32'd2);
    check("if_rdata", if_rdata, 32'h00500093);
    check("if_err", 32'(if_err), 32'd0);
    @(posedge clk); #1;

    // byte lanes and extension
    st_chk("sw_0x100", 2'b10, 32'h100, 32'h11223344, 4'b1111);
    st_chk("sb_0x101", 2'b00, 32'h101, 32'h000000AB, 4'b0010);
    ld_chk("lb_0x101", 2'b00, 1'b0, 32'h101, 32'hFFFFFFAB);
    ld_chk("lbu_0x101", 2'b00, 1'b1, 32'h101, 32'h000000AB);
    ld_chk("lw_0x100a", 2'b10, 1'b0, 32'h100, 32'h1122AB44);

    // half lanes, other half untouched
    st_chk("sh_0x102", 2'b01, 32'h102, 32'h00008001, 4'b1100);
    ld_chk("lh_0x102", 2'b01, 1'b0, 32'h102, 32'hFFFF8001);
    ld_chk("lhu_0x102", 2'b01, 1'b1, 32'h102, 32'h00008001);
    ld_chk("lhu_0x100", 2'b01, 1'b1, 32'h100, 32'h0000AB44);
    ld_chk("lwu_0x100", 2'b10, 1'b1, 32'h100, 32'h8001AB44);

    // error cases: no RAM access, response one cycle after grant
    err_chk("lw_0x102", 1'b0, 2'b10, 32'h102);
    err_chk("lh_0x103", 1'b0, 2'b01, 32'h103);
    err_chk("size11", 1'b0, 2'b11, 32'h100);
    err_chk("lw_oor", 1'b0, 2'b10, 32'(MEM_WORDS) << 2);
    err_chk("sw_misal", 1'b1, 2'b10, 32'h102);
    err_chk("sb_oor", 1'b1, 2'b00, (32'(MEM_WORDS) << 2) + 32'd1);
    ld_chk("lw_0x100b", 2'b10, 1'b0, 32'h100, 32'h8001AB44);
    st_chk("sw_last", 2'b10, (32'(MEM_WORDS) - 32'd1) << 2, 32'hCAFEF00D, 4'b1111);
    ld_chk("lw_last", 2'b10, 1'b0, (32'(MEM_WORDS) - 32'd1) << 2, 32'hCAFEF00D);

    // both requesting every cycle: LS x4 then IF, repeating
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h100;
    seq = '0; gidx = 0; n_if_g = 0; n_ls_g = 0; n_if_v = 0; n_ls_v = 0; n_both = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (if_gnt && ls_gnt) n_both++;
      if (if_gnt || ls_gnt) begin
        if (gidx < 10) seq[gidx] = if_gnt;
        gidx++;
      end
      if (if_gnt) n_if_g++;
      if (ls_gnt) n_ls_g++;
      if (if_rvalid) n_if_v++;
      if (ls_rvalid) n_ls_v++;
      @(posedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("arb_seq", 32'(seq), 32'h210);
    check("arb_if_gnts", 32'(n_if_g), 32'd2);
    check("arb_ls_gnts", 32'(n_ls_g), 32'd8);
    check("arb_double_gnt", 32'(n_both), 32'd0);
    check("arb_if_rvalids", 32'(n_if_v), 32'd2);
    check("arb_ls_rvalids", 32'(n_ls_v), 32'd8);
    @(posedge clk); #1;

    // reset in the middle of an access
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h200; ls_wdata = 32'h5A5A5A5A;
    #1;
    check("rstmid_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1;
    ls_req = 1'b0; ls_we = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_rvalid0", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    check("rstmid_rdata", ls_rdata, 32'd0);
    @(posedge clk); #1;
    check("rstmid_rvalid1", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("rstmid_if_gnt", 32'(if_gnt), 32'd1);
    check("rstmid_ram_en", 32'(ram_en), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    k = 0;
    while (!if_rvalid && k < 6) begin
      if (ls_rvalid) check("rstmid_ls_pulse", 32'(ls_rvalid), 32'd0);
      @(posedge clk); #1; k++;
    end
    check("rstmid_if_rvalid", 32'(if_rvalid), 32'd1);
    check("rstmid_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("rstmid_if_rdata", if_rdata, 32'h00500093);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
